// File: rtl/store_buffer.sv
// Posted-write FIFO between the load/store unit and the data memory port.
// Optional store merging into the youngest RAM entry: define STORE_BUFFER_MERGE_EN.
module store_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RAM_BASE = 32'h0000_0000,
  parameter logic [31:0] RAM_TOP  = 32'h0010_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [3:0]               st_strb,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hazard,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_data,
  output logic [3:0]               mem_strb,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [3:0]    r_strb [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_nonempty;
  logic          w_merge;
  logic          w_push;
  logic          w_pop;
  logic          w_hazard;
  logic [PW-1:0] w_off;
  logic          w_unused;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_nonempty = (r_count != CW'(0));

`ifdef STORE_BUFFER_MERGE_EN
  logic [PW-1:0] w_young;
  logic          w_in_ram;

  // Youngest entry is never the head once two or more entries are pending.
  assign w_young  = r_tail - PW'(1);
  assign w_in_ram = ((st_addr - RAM_BASE) < (RAM_TOP - RAM_BASE));
  assign w_merge  = st_valid && (r_count >= CW'(2)) && w_in_ram &&
                    (r_addr[w_young][31:2] == st_addr[31:2]);
  assign w_unused = ^{ld_addr[1:0]};
`else
  assign w_merge  = 1'b0;
  assign w_unused = ^{ld_addr[1:0], RAM_BASE, RAM_TOP};
`endif

  assign st_ready  = !w_full || w_merge;
  assign w_push    = st_valid && !w_full && !w_merge;
  assign w_pop     = w_nonempty && mem_ready;

  assign mem_valid = w_nonempty;
  assign mem_addr  = w_nonempty ? r_addr[r_head] : 32'h0;
  assign mem_data  = w_nonempty ? r_data[r_head] : 32'h0;
  assign mem_strb  = w_nonempty ? r_strb[r_head] : 4'h0;
  assign empty     = !w_nonempty;
  assign count     = r_count;
  assign ld_hazard = w_hazard;

  // Word-address match against every occupied slot; same-cycle stores excluded.
  always_comb begin
    w_hazard = 1'b0;
    w_off    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_head;
      if ((CW'(w_off) < r_count) && (r_addr[PW'(i)][31:2] == ld_addr[31:2]))
        w_hazard = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload needs no reset: occupancy is tracked by head/count alone.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
      r_strb[r_tail] <= st_strb;
    end
`ifdef STORE_BUFFER_MERGE_EN
    if (w_merge) begin
      for (int b = 0; b < 4; b++)
        if (st_strb[b]) r_data[w_young][8*b +: 8] <= st_data[8*b +: 8];
      r_strb[w_young] <= r_strb[w_young] | st_strb;
    end
`endif
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the load/store unit and the data memory bus. Accepts stores from the pipeline in one cycle, holds up to DEPTH entries in FIFO order, and drains them to memory through a valid/ready port so the pipeline does not stall on write latency. Provides a load-hazard flag so loads to a word with a pending store wait until it has drained, plus an empty flag for fences.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2 (sized from writebuffer_depth)
- RAM_BASE, 32'h000000, inclusive base of the mergeable RAM region
- RAM_TOP, 32'h100000, exclusive top of the mergeable RAM region

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- st_valid  in  1  store request
- st_ready  out  1  buffer can accept a store this cycle
- st_addr  in  32  byte address
- st_data  in  32  write data, byte-lane aligned
- st_strb  in  4  byte enables, nonzero
- ld_addr  in  32  address of the load being issued
- ld_hazard  out  1  a valid entry matches ld_addr[31:2]
- mem_valid  out  1  head entry presented to memory
- mem_ready  in  1  memory accepts head entry
- mem_addr  out  32  head address
- mem_data  out  32  head data
- mem_strb  out  4  head byte enables
- empty  out  1  no valid entries
- count  out  $clog2(DEPTH)+1  number of valid entries

## Operation

- Storage: circular array of DEPTH entries {addr, data, strb}; head/tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
- Push: st_valid && st_ready writes the entry at tail; tail++ and count++.
- Pop: mem_valid && mem_ready retires the head; head++ and count--.
- Simultaneous push and pop: both pointers advance; count unchanged.
- st_ready = (count != DEPTH). A pop in the same cycle does not raise st_ready when full; there is no pass-through.
- mem_valid = (count != 0). mem_addr/data/strb come from the head entry and must stay stable while mem_valid && !mem_ready.
- ld_hazard = OR over valid entries of (entry.addr[31:2] == ld_addr[31:2]); combinational on ld_addr and registered state. Byte enables are ignored, so any word match is a hazard.
- empty = (count == 0); fences wait on empty.
- Ordering: entries drain strictly in acceptance order, including addresses outside RAM_BASE..RAM_TOP (IO: print, clint, plic).
- Reset: head = tail = count = 0; all entries invalid. Reset mid-drain discards every pending store. Output values at reset: st_ready=1, mem_valid=0, empty=1, count=0, ld_hazard=0, mem_addr/data/strb=0.

## Timing

- A store accepted at edge N is visible on the mem port, ld_hazard and count from cycle N+1. Minimum store-to-memory latency is 1 cycle.
- Pop throughput is 1 per cycle; push throughput is 1 per cycle while not full.
- ld_hazard does not include a store presented on st_* in the same cycle. The pipeline orders a same-cycle load after the store.
- From full, with st_valid held and mem_ready=1 every cycle, the buffer accepts 1 store per cycle beginning the cycle after the first pop.

## Configuration

- Macro STORE_BUFFER_MERGE_EN.
- Defined: a store merges into the youngest entry instead of allocating when all of these hold:
  - count ≥ 2 (the youngest entry is not the head being presented);
  - the store's word address equals the youngest entry's word address;
  - the address lies in [RAM_BASE, RAM_TOP).
- On a merge, bytes with st_strb set overwrite data, strb becomes the OR of old and new strb, count and tail are unchanged, and st_ready is 1 even when full.
- Undefined: every store allocates a new entry. No merge logic is built.

## Test plan

- Reset, then push 0x100/0xAABBCCDD/4'hF with mem_ready=0 -> next cycle mem_valid=1, mem_addr=0x100, count=1, ld_hazard=1 for ld_addr=0x102; mem_ready=1 -> count=0, empty=1.
- Push 4 stores with mem_ready=0 -> count=4, st_ready=0, a 5th store stalls. Raise mem_ready -> drain in order 0x10,0x20,0x30,0x40, and the 5th store is accepted the cycle after the first pop.
- Continuous push+pop for 20 cycles with distinct addresses -> count stays 1, pointers wrap, mem sequence matches push order exactly.
- Reset asserted with 3 entries pending -> next cycle count=0, mem_valid=0, no further mem handshakes.
- MERGE_EN: push 0x200 strb 4'h1 data 0x11, then 0x300, then 0x300 strb 4'h2 data 0x2200 -> count=2, second entry strb 4'h3. The same sequence at 0x1000000 -> count=3 (no merge in IO).
- Without MERGE_EN: the same sequence at 0x300 -> count=3.
